// File: rtl/handshake_rx_arb.sv
// -----------------------------------------------------------------------------
// handshake_rx_arb
// Receive side of several toggle-based clock-domain-crossing handshakes.
// Each remote request toggle is synchronized into clk. Pending channels are
// served round-robin into one valid/ready output register. Each captured
// channel gets its acknowledge toggle flipped so its sender may move on.
//
// Ports:
//   clk        sole clock
//   rst_n      asynchronous active-low reset
//   req_tgl    per-channel request toggles (asynchronous to clk)
//   req_data   per-channel data words, channel c at [c*WIDTH +: WIDTH]
//   ack_tgl    per-channel acknowledge toggles (registered)
//   pending    per-channel request-outstanding flags
//   out_valid  output word valid
//   out_ready  consumer accepts the output word
//   out_data   captured word
//   out_chan   channel index that supplied out_data
// -----------------------------------------------------------------------------
module handshake_rx_arb #(
   parameter  int CHANNELS    = 4,
   parameter  int WIDTH       = 8,
   parameter  int SYNC_STAGES = 2,
   localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       req_tgl,
   input  logic [CHANNELS*WIDTH-1:0] req_data,
   output logic [CHANNELS-1:0]       ack_tgl,
   output logic [CHANNELS-1:0]       pending,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [CW-1:0]             out_chan
);

   logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
   logic [CHANNELS-1:0] r_ack;
   logic [CW-1:0]       r_last;
   logic                r_valid;
   logic [WIDTH-1:0]    r_data;
   logic [CW-1:0]       r_chan;

   logic [CHANNELS-1:0] w_req_s;
   logic [CHANNELS-1:0] w_pending;
   logic                w_load;
   logic                w_hi_found;
   logic [CW-1:0]       w_hi_idx;
   logic [CW-1:0]       w_lo_idx;
   logic [CW-1:0]       w_grant;
   logic [CHANNELS-1:0] w_grant_oh;
   logic [WIDTH-1:0]    w_grant_data;

   // ---- synchronizer: only these flops see the raw request toggles --------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= req_tgl;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_req_s   = r_sync[SYNC_STAGES-1];
   // Level compare: the ack flip on capture clears it, so no edge detector.
   assign w_pending = w_req_s ^ r_ack;
   assign w_load    = (|w_pending) && (!r_valid || out_ready);

   // ---- round-robin arbiter ------------------------------------------------
   // Lowest pending index above last_grant wins; otherwise the lowest pending
   // index at or below it (wrap-around). Descending loop: last write wins.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int c = CHANNELS-1; c >= 0; c--) begin
         if (w_pending[c]) begin
            if (c > int'(r_last)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = CW'(c);
            end else begin
               w_lo_idx = CW'(c);
            end
         end
      end
      w_grant = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      w_grant_oh   = '0;
      w_grant_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (CW'(c) == w_grant) begin
            w_grant_oh[c] = 1'b1;
            w_grant_data  = req_data[c*WIDTH +: WIDTH];
         end
      end
   end

   // ---- output register, acknowledge toggles, grant pointer ---------------
   // A load also covers the drain of the previous word in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_ack   <= '0;
         r_last  <= CW'(CHANNELS-1);
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= w_grant_data;
         r_chan  <= w_grant;
         r_ack   <= r_ack ^ w_grant_oh;
         r_last  <= w_grant;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign ack_tgl   = r_ack;
   assign pending   = w_pending;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_chan  = r_chan;

endmodule

// File: tb/tb_handshake_rx_arb.sv
// -----------------------------------------------------------------------------
// Self-checking bench for handshake_rx_arb (CHANNELS=4, WIDTH=8, SYNC_STAGES=2).
// A behavioural model (delay queue for the synchronizer, modular round-robin
// search) is stepped once per clock; directed scenarios add explicit checks.
// -----------------------------------------------------------------------------
module tb_handshake_rx_arb;
   localparam int CH = 4;
   localparam int W  = 8;
   localparam int SS = 2;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH-1:0]     req_tgl;
   logic [CH*W-1:0]   req_data;
   logic              out_ready;
   logic [CH-1:0]     ack_tgl;
   logic [CH-1:0]     pending;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [CW-1:0]     out_chan;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   logic [CH-1:0] q_s[$];
   logic [CH-1:0] m_ack;
   int            m_last;
   logic          m_valid;
   logic [W-1:0]  m_data;
   int            m_chan;

   handshake_rx_arb #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_tgl   (req_tgl),
      .req_data  (req_data),
      .ack_tgl   (ack_tgl),
      .pending   (pending),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_s.delete();
      for (int i = 0; i < SS; i++) q_s.push_back('0);
      m_ack   = '0;
      m_last  = CH-1;
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
   endtask

   // One clock edge of the model, using the inputs currently driven.
   task automatic model_edge();
      logic [CH-1:0] pend;
      int g;
      pend = q_s[0] ^ m_ack;
      if (pend != '0 && (!m_valid || out_ready)) begin
         g = -1;
         for (int k = 1; k <= CH; k++)
            if (g < 0 && pend[(m_last + k) % CH]) g = (m_last + k) % CH;
         m_data   = req_data[g*W +: W];
         m_chan   = g;
         m_valid  = 1'b1;
         m_ack[g] = ~m_ack[g];
         m_last   = g;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      void'(q_s.pop_front());
      q_s.push_back(req_tgl);
   endtask

   task automatic check_model();
      chk("m_valid",   out_valid, m_valid);
      chk("m_data",    out_data,  m_data);
      chk("m_chan",    out_chan,  m_chan);
      chk("m_ack",     ack_tgl,   m_ack);
      chk("m_pending", pending,   q_s[0] ^ m_ack);
   endtask

   // Called at a negedge; ends at the next negedge after checking.
   task automatic cycle();
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic send(input int c, input logic [W-1:0] d);
      req_data[c*W +: W] = d;
      req_tgl[c]         = ~req_tgl[c];
   endtask

   task automatic reset_pulse(input string tag);
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      req_tgl = '0;
      #1;
      chk({tag, "_valid"},   out_valid, 0);
      chk({tag, "_data"},    out_data,  0);
      chk({tag, "_chan"},    out_chan,  0);
      chk({tag, "_ack"},     ack_tgl,   0);
      chk({tag, "_pending"}, pending,   0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk({tag, "_rel_pending"}, pending,   0);
      chk({tag, "_rel_valid"},   out_valid, 0);
   endtask

   initial begin
      logic [CH-1:0] ack_save;
      int words;

      rst_n     = 1'b1;
      req_tgl   = '0;
      req_data  = '0;
      out_ready = 1'b1;

      // 1: power-on reset, then a captured word discarded by a mid-clock reset
      #1 rst_n = 1'b0;
      #1;
      chk("por_valid", out_valid, 0);
      chk("por_ack",   ack_tgl,   0);
      chk("por_data",  out_data,  0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("por_rel_pending", pending, 0);
      out_ready = 1'b0;
      send(0, 8'h5A);
      repeat (3) cycle();
      chk("t1_loaded_valid", out_valid, 1);
      reset_pulse("t1_rst");
      out_ready = 1'b1;

      // 3: simultaneous burst, fresh priority starts at channel 0
      ack_save = ack_tgl;
      for (int c = 0; c < CH; c++) send(c, 8'h10 + W'(c));
      repeat (2) cycle();
      chk("t3_early_valid", out_valid, 0);
      for (int i = 0; i < CH; i++) begin
         cycle();
         chk("t3_valid", out_valid, 1);
         chk("t3_chan",  out_chan,  i);
         chk("t3_data",  out_data,  8'h10 + i);
      end
      cycle();
      chk("t3_done_valid", out_valid, 0);
      chk("t3_ack_once",   ack_tgl,   ack_save ^ 4'hF);

      // 2: single request on channel 2
      ack_save = ack_tgl;
      send(2, 8'hA5);
      repeat (2) cycle();
      chk("t2_not_yet",  out_valid, 0);
      cycle();
      chk("t2_valid",    out_valid, 1);
      chk("t2_data",     out_data,  8'hA5);
      chk("t2_chan",     out_chan,  2);
      chk("t2_ack",      ack_tgl,   ack_save ^ 4'b0100);
      cycle();
      chk("t2_one_cycle", out_valid, 0);
      chk("t2_pending",  pending[2], 0);

      // 4: backpressure holds channel 1 while channel 3 waits
      out_ready = 1'b0;
      send(1, 8'h55);
      repeat (3) cycle();
      chk("t4_cap_chan", out_chan, 1);
      send(3, 8'h77);
      ack_save = ack_tgl;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_chan",  out_chan,  1);
         chk("t4_hold_data",  out_data,  8'h55);
         chk("t4_hold_ack",   ack_tgl,   ack_save);
      end
      chk("t4_ch3_pending", pending[3], 1);
      out_ready = 1'b1;
      cycle();
      chk("t4_nobubble_valid", out_valid, 1);
      chk("t4_nobubble_chan",  out_chan,  3);
      chk("t4_nobubble_data",  out_data,  8'h77);
      cycle();
      chk("t4_drained", out_valid, 0);

      // 5: fairness between two greedy senders
      words = 0;
      for (int cyc = 0; cyc < 1500 && words < 100; cyc++) begin
         for (int c = 0; c < 2; c++)
            if (req_tgl[c] == ack_tgl[c]) send(c, W'($urandom));
         cycle();
         if (out_valid) begin
            chk("t5_alternate", out_chan, words % 2);
            words++;
         end
      end
      chk("t5_words", words, 100);
      repeat (6) cycle();

      // 6: reset while a word sits in the output register
      reset_pulse("t6_pre");
      send(0, 8'h11);
      send(2, 8'h22);
      repeat (4) cycle();
      chk("t6_valid", out_valid, 1);
      chk("t6_ack",   ack_tgl,   4'b0101);
      out_ready = 1'b0;
      reset_pulse("t6_rst");
      out_ready = 1'b1;
      send(0, 8'h3C);
      repeat (3) cycle();
      chk("t6_after_valid", out_valid, 1);
      chk("t6_after_chan",  out_chan,  0);
      chk("t6_after_data",  out_data,  8'h3C);

      // random traffic against the model
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < CH; c++)
            if (req_tgl[c] == ack_tgl[c] && $urandom_range(0, 2) == 0)
               send(c, W'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      out_ready = 1'b1;
      repeat (10) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
